// File: rtl/game_countdown_timer.sv
// game_countdown_timer: countdown timer with a 1 Hz prescaler, pause, bonus add, warning flag and BCD digits.
// Ports: clk/rst_n      system clock, async active-low reset
//        start_i        pulse, load START_SEC and run (restarts from any state)
//        pause_i        level, hold countdown and prescaler
//        add_en_i       pulse, add add_sec_i (saturating at MAX_SEC)
//        seconds_o      remaining seconds; tens_o/ones_o its BCD digits
//        sec_tick_o     one-cycle pulse per counted second
//        running_o      in RUN; warning_o low-time flag; time_up_o in DONE
module game_countdown_timer #(
  parameter int TICK_DIV  = 50000000,
  parameter int WIDTH     = 8,
  parameter int START_SEC = 60,
  parameter int MAX_SEC   = 99,
  parameter int WARN_SEC  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             pause_i,
  input  logic             add_en_i,
  input  logic [WIDTH-1:0] add_sec_i,
  output logic [WIDTH-1:0] seconds_o,
  output logic [3:0]       tens_o,
  output logic [3:0]       ones_o,
  output logic             sec_tick_o,
  output logic             running_o,
  output logic             warning_o,
  output logic             time_up_o
);
  localparam int PW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [WIDTH-1:0] sec_q, sec_d;
  logic tick_q, up_q, up_d, tick;
  logic [WIDTH:0] sum, nxt;
  always_comb begin
    // start overrides everything, so a coinciding wrap is not a tick
    tick = !start_i && state_q == RUN && !pause_i && presc_q == PW'(TICK_DIV - 1);
    // one extra bit keeps the bonus add from wrapping before saturation
    sum = {1'b0, sec_q} - {{WIDTH{1'b0}}, tick} + (add_en_i ? {1'b0, add_sec_i} : '0);
    nxt = sum > (WIDTH+1)'(MAX_SEC) ? (WIDTH+1)'(MAX_SEC) : sum;
    state_d = state_q;
    presc_d = presc_q;
    sec_d   = sec_q;
    up_d    = up_q;
    if (start_i) begin
      sec_d   = WIDTH'(START_SEC);
      presc_d = '0;
      state_d = START_SEC == 0 ? DONE : RUN;
      up_d    = START_SEC == 0;
    end else if (state_q == RUN || state_q == PAUSED) begin
      sec_d = nxt[WIDTH-1:0];
      if (state_q == RUN && !pause_i) presc_d = tick ? '0 : presc_q + PW'(1);
      if (nxt == '0) begin
        state_d = DONE;
        presc_d = '0;
        up_d    = 1'b1;
      end else begin
        state_d = pause_i ? PAUSED : RUN;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      sec_q   <= WIDTH'(START_SEC);
      tick_q  <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      tick_q  <= tick;
      up_q    <= up_d;
    end
  end
  assign seconds_o  = sec_q;
  assign tens_o     = 4'(sec_q / 10);
  assign ones_o     = 4'(sec_q % 10);
  assign sec_tick_o = tick_q;
  assign time_up_o  = up_q;
  assign running_o  = state_q == RUN;
  assign warning_o  = (state_q == RUN || state_q == PAUSED) && sec_q != '0 && sec_q <= WIDTH'(WARN_SEC);
endmodule

// File: tb/tb_game_countdown_timer.sv
// tb_game_countdown_timer: self-checking bench for game_countdown_timer.
module tb_game_countdown_timer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, pause = 1'b0, add_en = 1'b0;
  logic [7:0] add_sec = '0, seconds;
  logic [3:0] tens, ones;
  logic sec_tick, running, warning, time_up;
  logic start2 = 1'b0, pause2 = 1'b0, add_en2 = 1'b0;
  logic [7:0] add_sec2 = '0, seconds2;
  logic [3:0] tens2, ones2;
  logic sec_tick2, running2, warning2, time_up2;
  int tests = 0, fails = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  game_countdown_timer #(.TICK_DIV(4), .WIDTH(8), .START_SEC(5), .MAX_SEC(9), .WARN_SEC(2)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .pause_i(pause), .add_en_i(add_en),
    .add_sec_i(add_sec), .seconds_o(seconds), .tens_o(tens), .ones_o(ones),
    .sec_tick_o(sec_tick), .running_o(running), .warning_o(warning), .time_up_o(time_up));

  game_countdown_timer #(.TICK_DIV(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .pause_i(pause2), .add_en_i(add_en2),
    .add_sec_i(add_sec2), .seconds_o(seconds2), .tens_o(tens2), .ones_o(ones2),
    .sec_tick_o(sec_tick2), .running_o(running2), .warning_o(warning2), .time_up_o(time_up2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_sec(input int s);
    for (int i = 0; i < 40 && seconds != 8'(s); i++) step();
    tests++;
    if (seconds !== 8'(s)) begin fails++; $display("FAIL wait_sec: seconds=%0d required=%0d", seconds, s); end
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({seconds, tens, ones, sec_tick, running, warning, time_up} !== {8'd5, 4'd0, 4'd5, 4'b0000}) begin
      fails++; $display("FAIL reset_values: seconds=%0d tens=%0d ones=%0d tick=%b run=%b warn=%b up=%b", seconds, tens, ones, sec_tick, running, warning, time_up);
    end
    rst_n = 1'b1;
    add_en = 1'b1; add_sec = 8'd3;
    step();
    add_en = 1'b0;
    step();
    tests++;
    if ({seconds, sec_tick, running, time_up} !== {8'd5, 3'b000}) begin
      fails++; $display("FAIL idle_add_ignored: seconds=%0d tick=%b run=%b up=%b, required 5 0 0 0", seconds, sec_tick, running, time_up);
    end
  endtask

  task automatic test_countdown();
    int cur, last, cyc;
    logic [10:0] exp_v;
    pulse_start();
    tests++;
    if ({seconds, running} !== {8'd5, 1'b1}) begin fails++; $display("FAIL start_load: seconds=%0d running=%b", seconds, running); end
    for (int s = 4; s >= 0; s--) exp_q.push_back(s);
    cur = 5; last = 0; cyc = 0;
    while (cyc < 40 && cur != 0) begin
      step();
      cyc++;
      if (sec_tick) begin
        cur = exp_q.pop_front();
        tests++;
        if (cyc - last != 4) begin fails++; $display("FAIL tick_period: got %0d cycles, required 4", cyc - last); end
        last = cyc;
      end
      exp_v = {8'(cur), cur == 1 || cur == 2, cur == 0, cur != 0};
      tests++;
      if ({seconds, warning, time_up, running} !== exp_v) begin
        fails++; $display("FAIL countdown cyc %0d: sec=%0d warn=%b up=%b run=%b, required %0d %b %b %b", cyc, seconds, warning, time_up, running, exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
    tests++;
    if (cur != 0 || exp_q.size() != 0) begin fails++; $display("FAIL countdown_timeout: %0d ticks missing", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_pause();
    int n;
    pulse_start();
    step(); step();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if ({sec_tick, running, seconds} !== {2'b00, 8'd5}) begin
        fails++; $display("FAIL paused_hold %0d: tick=%b run=%b sec=%0d, required 0 0 5", i, sec_tick, running, seconds);
      end
    end
    pause = 1'b0;
    step();
    tests++;
    if ({running, sec_tick} !== 2'b10) begin fails++; $display("FAIL resume: run=%b tick=%b, required 1 0", running, sec_tick); end
    exp_q.push_back(2);
    exp_q.push_back(4);
    n = 0;
    while (!sec_tick && n < 10) begin step(); n++; end
    tests++;
    if (n != exp_q.pop_front()) begin fails++; $display("FAIL resume_tick_delay: %0d cycles, required 2", n); end
    tests++;
    if (seconds != 8'(exp_q.pop_front())) begin fails++; $display("FAIL resume_tick_sec: seconds=%0d required 4", seconds); end
  endtask

  task automatic test_add();
    pulse_start();
    wait_sec(3);
    add_en = 1'b1; add_sec = 8'd8;
    step();
    add_en = 1'b0;
    tests++;
    if ({seconds, tens, ones, warning} !== {8'd9, 4'd0, 4'd9, 1'b0}) begin
      fails++; $display("FAIL add_saturate: sec=%0d tens=%0d ones=%0d warn=%b, required 9 0 9 0", seconds, tens, ones, warning);
    end
    pause = 1'b1;
    step();
    add_en = 1'b1; add_sec = 8'd8;
    step();
    add_en = 1'b0;
    tests++;
    if ({seconds, running, time_up} !== {8'd9, 2'b00}) begin
      fails++; $display("FAIL add_paused: sec=%0d run=%b up=%b, required 9 0 0", seconds, running, time_up);
    end
    pause = 1'b0;
  endtask

  task automatic test_coincide();
    int n;
    pulse_start();
    wait_sec(1);
    step(); step(); step();
    add_en = 1'b1; add_sec = 8'd2;
    step();
    add_en = 1'b0;
    tests++;
    if ({seconds, sec_tick, time_up, running, warning} !== {8'd2, 4'b1011}) begin
      fails++; $display("FAIL tick_add_coincide: sec=%0d tick=%b up=%b run=%b warn=%b, required 2 1 0 1 1", seconds, sec_tick, time_up, running, warning);
    end
    n = 0;
    while (!time_up && n < 20) begin step(); n++; end
    tests++;
    if (n != 8) begin fails++; $display("FAIL expire_delay: %0d cycles, required 8", n); end
    tests++;
    if ({seconds, running, warning, time_up} !== {8'd0, 3'b001}) begin
      fails++; $display("FAIL expire_state: sec=%0d run=%b warn=%b up=%b, required 0 0 0 1", seconds, running, warning, time_up);
    end
  endtask

  task automatic test_done();
    add_en = 1'b1; add_sec = 8'd5;
    step();
    add_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      tests++;
      if ({seconds, time_up, running, sec_tick} !== {8'd0, 3'b100}) begin
        fails++; $display("FAIL done_hold %0d: sec=%0d up=%b run=%b tick=%b, required 0 1 0 0", i, seconds, time_up, running, sec_tick);
      end
    end
    pulse_start();
    tests++;
    if ({seconds, time_up, running} !== {8'd5, 2'b01}) begin
      fails++; $display("FAIL done_restart: sec=%0d up=%b run=%b, required 5 0 1", seconds, time_up, running);
    end
  endtask

  task automatic test_reset_mid();
    wait_sec(3);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({seconds, tens, ones, sec_tick, running, warning, time_up} !== {8'd5, 4'd0, 4'd5, 4'b0000}) begin
      fails++; $display("FAIL async_reset: sec=%0d tens=%0d ones=%0d tick=%b run=%b warn=%b up=%b", seconds, tens, ones, sec_tick, running, warning, time_up);
    end
    #3;
    rst_n = 1'b1;
    step();
    tests++;
    if ({seconds, sec_tick, running} !== {8'd5, 2'b00}) begin
      fails++; $display("FAIL reset_release: sec=%0d tick=%b run=%b, required 5 0 0", seconds, sec_tick, running);
    end
  endtask

  task automatic test_bcd();
    int e;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    tests++;
    if ({seconds2, tens2, ones2} !== {8'd60, 4'd6, 4'd0}) begin
      fails++; $display("FAIL bcd_start: sec=%0d tens=%0d ones=%0d, required 60 6 0", seconds2, tens2, ones2);
    end
    for (int s = 59; s >= 47; s--) exp_q.push_back(s);
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
      step();
      if (sec_tick2) begin
        e = exp_q.pop_front();
        tests++;
        if ({seconds2, tens2, ones2} !== {8'(e), 4'(e / 10), 4'(e % 10)}) begin
          fails++; $display("FAIL bcd_count: sec=%0d tens=%0d ones=%0d, required %0d %0d %0d", seconds2, tens2, ones2, e, e / 10, e % 10);
        end
      end
    end
    tests++;
    if ({seconds2, tens2, ones2} !== {8'd47, 4'd4, 4'd7}) begin
      fails++; $display("FAIL bcd_47: sec=%0d tens=%0d ones=%0d, required 47 4 7", seconds2, tens2, ones2);
      exp_q.delete();
    end
    add_en2 = 1'b1; add_sec2 = 8'd200;
    step();
    add_en2 = 1'b0;
    tests++;
    if ({seconds2, tens2, ones2} !== {8'd99, 4'd9, 4'd9}) begin
      fails++; $display("FAIL bcd_99: sec=%0d tens=%0d ones=%0d, required 99 9 9", seconds2, tens2, ones2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_add();
    test_coincide();
    test_done();
    test_reset_mid();
    test_bcd();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/game_countdown_timer.md
Name: game_countdown_timer

Overview:
- Parametrised countdown timer for the coin-catcher game.
- Runs from the system clock using an internal 1 Hz prescaler, so no separate slow clock is needed.
- Adds start/restart, pause/resume, saturating bonus-time add, a low-time warning flag, and BCD digits for the 7-segment display driver.
- Sits between the game control FSM (start, pause, bonus) and the score/display logic (seconds, digits, time_up).

Parameters:
- TICK_DIV, 50000000: system-clock cycles per game second. Must be ≥ 2.
- WIDTH, 8: width of the seconds counter and of add_sec.
- START_SEC, 60: value loaded on start. Must satisfy START_SEC ≤ MAX_SEC.
- MAX_SEC, 99: saturation ceiling for bonus adds. Must be ≤ 99 and < 2^WIDTH.
- WARN_SEC, 10: warning asserted while 0 < seconds ≤ WARN_SEC and the timer is active.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  1-cycle pulse: load START_SEC and run. Also restarts from any state.
- pause  input  1  level: hold countdown while high.
- add_en  input  1  1-cycle pulse: add add_sec to seconds.
- add_sec  input  WIDTH  bonus seconds, sampled when add_en=1.
- seconds  output  WIDTH  remaining seconds (registered).
- tens  output  4  BCD tens digit of seconds.
- ones  output  4  BCD ones digit of seconds.
- sec_tick  output  1  1-cycle pulse on each counted second (registered).
- running  output  1  high in RUN state.
- warning  output  1  low-time flag.
- time_up  output  1  high in DONE state (registered).

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, seconds=START_SEC, prescaler=0.
  - sec_tick=0, time_up=0, running=0, warning=0.
- States: IDLE, RUN, PAUSED, DONE.
- start=1 (any state, highest priority after reset):
  - seconds←START_SEC, prescaler←0, time_up←0.
  - Next state is RUN, or DONE if START_SEC=0 (time_up←1 in that case).
  - pause, add_en and tick are all ignored that cycle.
- IDLE: holds seconds=START_SEC. Only start has effect.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps to 0.
  - The wrap cycle is a tick: sec_tick=1 on the following cycle, for exactly 1 cycle.
  - pause=1 → PAUSED on the next edge. The prescaler value is frozen, with no tick that cycle.
- PAUSED:
  - Prescaler and seconds hold.
  - pause=0 → RUN, resuming from the frozen prescaler value, so the partial second is preserved.
- Seconds update in RUN/PAUSED:
  - next = min(seconds − tick + (add_en ? add_sec : 0), MAX_SEC), computed at WIDTH+1 bits.
  - If next=0: seconds←0, state←DONE, time_up←1 on the same edge.
  - If tick and add coincide at seconds=1 with add_sec>0, the timer does not expire.
- add_en is ignored in IDLE and DONE.
- DONE:
  - seconds=0, time_up=1, running=0, prescaler held at 0.
  - Stays in DONE until start or reset.
- running = (state==RUN).
- warning = (state∈{RUN,PAUSED}) && seconds≠0 && seconds≤WARN_SEC. Decoded combinationally from registers.
- tens = seconds/10, ones = seconds%10. Combinational decode, valid for 0..99.
- Reset asserted mid-count returns to IDLE immediately. No tick is emitted on the cycle reset releases.

Test Plan (TICK_DIV=4, START_SEC=5, MAX_SEC=9, WARN_SEC=2 unless noted):
- Reset, then start pulse:
  - seconds=5, running=1.
  - sec_tick every 4 cycles; seconds 5→4→3→2→1→0.
  - time_up=1 and running=0 on the edge seconds reaches 0.
  - warning=1 only while seconds∈{2,1}.
- Start, hold pause high for 10 cycles after 2 prescaler counts, then release:
  - seconds frozen during pause, no sec_tick.
  - First tick arrives 2 cycles after resume.
- At seconds=3, add_en with add_sec=8 → seconds=9 (saturated). Repeat with add_en in PAUSED → seconds stays 9.
- At seconds=1, add_en with add_sec=2 coincident with a tick → seconds=2, no time_up. Then let the timer expire normally.
- In DONE, pulse start → seconds=5, time_up=0, running=1. Pulse add_en in DONE beforehand → no change.
- Assert reset mid-run at seconds=3 → all outputs return to reset values asynchronously.
- Default parameters, seconds=47 → tens=4, ones=7.
